rs_issue_queue: RTL and testbench
=================================

RS_ISSUE_QUEUE -- requirements
Module: rs_issue_queue

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 rsLine_a  input  rsEntry  first dispatched entry; accepted only when .valid=1.
REQ-004 rsLine_b  input  rsEntry  second dispatched entry; accepted only when .valid=1; younger than a.
REQ-005 cdb_valid  input  3  completion broadcast valid, one bit per FU (0=ALU0, 1=ALU1, 2=MEM).
REQ-006 cdb_tag  input  3x6  physical register tag written by each completing FU.
REQ-007 fu_ready  input  3  FU k can accept an instruction this cycle.
REQ-008 issue_valid  output  3  registered; FU k receives issue_entry[k] this cycle.
REQ-009 issue_entry  output  3 x rsEntry  registered; entry issued to FU k.
REQ-010 rs_full  output  1  fewer than 2 free slots.
REQ-011 rs_count  output  5  occupied-slot count, 0..16.
REQ-012 overflow_err  output  1  sticky; a valid dispatch was dropped for lack of a free slot.
REQ-013 bad_fu_err  output  1  sticky; an entry with fu=2'b11 was written.

Function
REQ-014 Storage: 16 slots, each holding one rsEntry; slot occupied iff its valid=1.
REQ-015 Allocation: a written to lowest-index free slot, b to next-lowest free slot; b alone (a.valid=0) takes lowest free slot.
REQ-016 Free slot: valid=0 at the start of the cycle; a slot vacated by issue at edge N is reusable from cycle N+1 only.
REQ-017 Insufficient free slots: accept what fits in a-then-b order, drop the rest, set overflow_err; stored state is never overwritten.
REQ-018 Wakeup: for each occupied slot and each cdb_valid[k], src1rdy set if instruction.rs1==cdb_tag[k]; src2rdy set if instruction.control.ALUSrc=0 and rs2==cdb_tag[k].
REQ-019 Same-cycle bypass: an entry being written sees the same cycle's broadcasts before storage; a and b tags both checked.
REQ-020 Tag 0 (x0) is always ready: rs1/rs2 equal to 0 force the corresponding rdy bit to 1 on write.
REQ-021 Eligibility: occupied, src1rdy=1, src2rdy=1 (registered values), fu=k, fu_ready[k]=1; wakeups in cycle N make the entry eligible in cycle N+1.
REQ-022 Select: per FU, lowest-index eligible slot; at most one issue per FU per cycle; three FUs issue independently.
REQ-023 Issue: at edge after select, issue_valid[k]=1, issue_entry[k]=selected slot contents, slot valid cleared; otherwise issue_valid[k]=0 and issue_entry[k] holds its last value.
REQ-024 fu=2'b11 entries are stored but never issue; write sets bad_fu_err.
REQ-025 rs_count = count of occupied slots after the edge (adds accepted writes, subtracts issues; simultaneous add+sub in same cycle nets correctly).
REQ-026 rs_full combinational from registered occupancy: free slots < 2.

Reset
REQ-027 On reset: all slot valid=0, issue_valid=0, issue_entry all-zero, rs_count=0, rs_full=0, overflow_err=0, bad_fu_err=0.
REQ-028 Reset dominates dispatch, wakeup and issue in the same cycle; no write or issue occurs.

Structure
REQ-029 Package typedefs holds RS_DEPTH=16, NUM_FU=3, FU encodings FU_ALU0/FU_ALU1/FU_MEM, and a cdbPort struct (valid, 6-bit tag); rsEntry and dispatchStruct stay there unchanged.
REQ-030 One sub-module rs_select: 16-bit eligibility vector in, one-hot grant plus found flag out; instantiated once per FU.

Verification
REQ-031 Reset, dispatch a(rs1=5 not ready, fu=ALU0) and b(ALUSrc=1, fu=ALU1, ready) -> b issues on ALU1 two edges after dispatch; a stays; rs_count=1.
REQ-032 cdb_valid[2]=1, tag=5 one cycle after REQ-031 -> a issues on ALU0 exactly two edges after broadcast.
REQ-033 Dispatch with rs1=9 while cdb_tag[0]=9 valid same cycle -> stored src1rdy=1, issues next cycle.
REQ-034 Fill 16 slots, fu_ready=0 -> rs_full=1, rs_count=16; one further dispatch pair -> overflow_err=1, contents unchanged.
REQ-035 Three ready ALU0 entries in slots 2,5,7, fu_ready[0]=1 -> issue order slots 2,5,7 on consecutive cycles; with fu_ready[0] dropped for one cycle, that cycle issue_valid[0]=0.
REQ-036 Reset asserted while entries pending and fu_ready=1 -> no issue that edge, rs_count=0 after.

Source files
------------

// File: rtl/rs_issue_queue_pkg.sv
// Shared types for the reservation-station issue queue: slot entry layout, CDB port,
// FU encodings and the wakeup helpers used on both stored and incoming entries.
package typedefs;

    localparam int unsigned RS_DEPTH = 16;
    localparam int unsigned NUM_FU   = 3;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned IDX_W    = $clog2(RS_DEPTH);
    localparam int unsigned CNT_W    = $clog2(RS_DEPTH + 1);

    localparam logic [1:0] FU_ALU0 = 2'b00;
    localparam logic [1:0] FU_ALU1 = 2'b01;
    localparam logic [1:0] FU_MEM  = 2'b10;
    localparam logic [1:0] FU_BAD  = 2'b11;

    typedef struct packed {
        logic       ALUSrc;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic [1:0] ALUOp;
    } controlStruct;

    typedef struct packed {
        logic [5:0]   rd;
        logic [5:0]   rs1;
        logic [5:0]   rs2;
        logic [15:0]  imm;
        controlStruct control;
    } dispatchStruct;

    typedef struct packed {
        logic          valid;
        dispatchStruct instruction;
        logic          src1rdy;
        logic          src2rdy;
        logic [1:0]    fu;
    } rsEntry;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } cdbPort;

    // rs2 is only a register operand when ALUSrc selects it.
    function automatic rsEntry wake_entry(rsEntry e, cdbPort [NUM_FU-1:0] cdb);
        rsEntry r;
        r = e;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            if (cdb[k].valid) begin
                if (e.instruction.rs1 == cdb[k].tag) r.src1rdy = 1'b1;
                if (!e.instruction.control.ALUSrc && e.instruction.rs2 == cdb[k].tag) begin
                    r.src2rdy = 1'b1;
                end
            end
        end
        return r;
    endfunction

    function automatic rsEntry prep_entry(rsEntry e, cdbPort [NUM_FU-1:0] cdb);
        rsEntry r;
        r = wake_entry(e, cdb);
        if (e.instruction.rs1 == '0) r.src1rdy = 1'b1;
        if (e.instruction.rs2 == '0) r.src2rdy = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch, completion-broadcast, issue and status signals of the issue queue.
interface rs_issue_queue_if;
    import typedefs::*;

    rsEntry                           rsLine_a;
    rsEntry                           rsLine_b;
    logic   [NUM_FU-1:0]              cdb_valid;
    logic   [NUM_FU-1:0][TAG_W-1:0]   cdb_tag;
    logic   [NUM_FU-1:0]              fu_ready;
    logic   [NUM_FU-1:0]              issue_valid;
    rsEntry [NUM_FU-1:0]              issue_entry;
    logic                             rs_full;
    logic   [CNT_W-1:0]               rs_count;
    logic                             overflow_err;
    logic                             bad_fu_err;

    modport master (
        output rsLine_a, rsLine_b, cdb_valid, cdb_tag, fu_ready,
        input  issue_valid, issue_entry, rs_full, rs_count, overflow_err, bad_fu_err
    );

    modport slave (
        input  rsLine_a, rsLine_b, cdb_valid, cdb_tag, fu_ready,
        output issue_valid, issue_entry, rs_full, rs_count, overflow_err, bad_fu_err
    );

endinterface

// File: rtl/rs_issue_queue_select.sv
// Lowest-index picker: one-hot grant of the lowest set eligibility bit.
module rs_select
    import typedefs::*;
(
    input  logic [RS_DEPTH-1:0] eligible,
    output logic [RS_DEPTH-1:0] grant,
    output logic                found
);

    // Two's complement isolates the lowest set bit.
    always_comb begin
        grant = eligible & (~eligible + RS_DEPTH'(1));
        found = |eligible;
    end

endmodule

// File: rtl/rs_issue_queue.sv
// 16-slot reservation station: dual dispatch, CDB wakeup with same-cycle bypass,
// independent lowest-index select and registered issue for ALU0, ALU1 and MEM.
module rs_issue_queue
    import typedefs::*;
(
    input logic             clk,
    input logic             reset,
    rs_issue_queue_if.slave bus
);

    rsEntry                          slot_q [RS_DEPTH];
    rsEntry                          slot_d [RS_DEPTH];
    logic   [NUM_FU-1:0]             issue_valid_q, issue_valid_d;
    rsEntry [NUM_FU-1:0]             issue_entry_q, issue_entry_d;
    logic                            overflow_err_q, overflow_err_d;
    logic                            bad_fu_err_q, bad_fu_err_d;

    cdbPort [NUM_FU-1:0]             cdb;
    logic   [NUM_FU-1:0][RS_DEPTH-1:0] eligible;
    logic   [NUM_FU-1:0][RS_DEPTH-1:0] grant;
    logic   [NUM_FU-1:0]             found;
    logic   [RS_DEPTH-1:0]           issued;

    logic   [IDX_W-1:0]              free0_idx, free1_idx;
    logic                            free0_ok, free1_ok;
    logic   [IDX_W-1:0]              idx_a, idx_b;
    logic                            wr_a, wr_b, drop;
    rsEntry                          line_a, line_b;
    logic   [CNT_W-1:0]              count;

    always_comb begin
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            cdb[k].valid = bus.cdb_valid[k];
            cdb[k].tag   = bus.cdb_tag[k];
        end
    end

    // Eligibility uses registered readiness only; wakeups land one cycle later.
    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                eligible[k][i] = slot_q[i].valid && slot_q[i].src1rdy && slot_q[i].src2rdy &&
                                 (slot_q[i].fu == 2'(k)) && bus.fu_ready[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_sel
        rs_select u_sel (
            .eligible (eligible[k]),
            .grant    (grant[k]),
            .found    (found[k])
        );
    end

    always_comb begin
        issued = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            issued = issued | grant[k];
        end
    end

    // Two lowest free slots, judged on start-of-cycle occupancy.
    always_comb begin
        free0_idx = '0;
        free1_idx = '0;
        free0_ok  = 1'b0;
        free1_ok  = 1'b0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (!slot_q[i].valid) begin
                if (!free0_ok) begin
                    free0_idx = IDX_W'(i);
                    free0_ok  = 1'b1;
                end else if (!free1_ok) begin
                    free1_idx = IDX_W'(i);
                    free1_ok  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_a  = bus.rsLine_a.valid && free0_ok;
        idx_a = free0_idx;
        if (bus.rsLine_a.valid) begin
            wr_b  = bus.rsLine_b.valid && free1_ok;
            idx_b = free1_idx;
        end else begin
            wr_b  = bus.rsLine_b.valid && free0_ok;
            idx_b = free0_idx;
        end
        drop   = (bus.rsLine_a.valid && !wr_a) || (bus.rsLine_b.valid && !wr_b);
        line_a = prep_entry(bus.rsLine_a, cdb);
        line_b = prep_entry(bus.rsLine_b, cdb);
    end

    always_comb begin
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (slot_q[i].valid) slot_d[i] = wake_entry(slot_q[i], cdb);
            if (issued[i]) slot_d[i].valid = 1'b0;
        end
        if (wr_a) slot_d[idx_a] = line_a;
        if (wr_b) slot_d[idx_b] = line_b;
    end

    always_comb begin
        issue_valid_d = found;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            issue_entry_d[k] = issue_entry_q[k];
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                if (grant[k][i]) issue_entry_d[k] = slot_q[i];
            end
        end
        overflow_err_d = overflow_err_q || drop;
        bad_fu_err_d   = bad_fu_err_q || (wr_a && bus.rsLine_a.fu == FU_BAD) ||
                         (wr_b && bus.rsLine_b.fu == FU_BAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            issue_valid_q  <= '0;
            issue_entry_q  <= '0;
            overflow_err_q <= 1'b0;
            bad_fu_err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
            issue_valid_q  <= issue_valid_d;
            issue_entry_q  <= issue_entry_d;
            overflow_err_q <= overflow_err_d;
            bad_fu_err_q   <= bad_fu_err_d;
        end
    end

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            count = count + CNT_W'(slot_q[i].valid);
        end
    end

    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_entry  = issue_entry_q;
    assign bus.rs_count     = count;
    assign bus.rs_full      = (count > CNT_W'(RS_DEPTH - 2));
    assign bus.overflow_err = overflow_err_q;
    assign bus.bad_fu_err   = bad_fu_err_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Scoreboard bench: a slot-array/free-list model predicts every post-edge output,
// a monitor compares them; directed scenarios plus a randomized phase.
module tb_rs_issue_queue;
    import typedefs::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rs_issue_queue_if bus ();

    rs_issue_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0]         iv;
        rsEntry [2:0]       ie;
        logic [CNT_W-1:0]   cnt;
        logic               full;
        logic               ovf;
        logic               bad;
    } exp_t;

    rsEntry         m_slot [RS_DEPTH];
    rsEntry [2:0]   m_ie;
    logic           m_ovf, m_bad;
    exp_t           exp_q [$];
    exp_t           mon_e;
    int             checks = 0;
    int             errors = 0;
    rsEntry         none = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic hit(input logic [2:0] cv, input logic [2:0][5:0] ct,
                                 input logic [5:0] tag);
        for (int k = 0; k < 3; k++) if (cv[k] && ct[k] == tag) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: occupancy is the valid bit, free slots form an ascending queue.
    task automatic model_step(input logic rst, input rsEntry a, input rsEntry b,
                              input logic [2:0] cv, input logic [2:0][5:0] ct,
                              input logic [2:0] fr);
        exp_t   e;
        int     free_list [$];
        int     picks [3];
        int     cnt;
        rsEntry dl [2];
        rsEntry w;
        e = '0;
        if (rst) begin
            for (int i = 0; i < RS_DEPTH; i++) m_slot[i] = '0;
            m_ie  = '0;
            m_ovf = 1'b0;
            m_bad = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                picks[k] = -1;
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (picks[k] < 0 && m_slot[i].valid && m_slot[i].src1rdy &&
                        m_slot[i].src2rdy && m_slot[i].fu == 2'(k) && fr[k]) picks[k] = i;
                end
                if (picks[k] >= 0) begin
                    e.iv[k] = 1'b1;
                    m_ie[k] = m_slot[picks[k]];
                end
            end
            for (int i = 0; i < RS_DEPTH; i++) if (!m_slot[i].valid) free_list.push_back(i);
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (m_slot[i].valid) begin
                    if (hit(cv, ct, m_slot[i].instruction.rs1)) m_slot[i].src1rdy = 1'b1;
                    if (!m_slot[i].instruction.control.ALUSrc &&
                        hit(cv, ct, m_slot[i].instruction.rs2)) m_slot[i].src2rdy = 1'b1;
                end
            end
            for (int k = 0; k < 3; k++) if (picks[k] >= 0) m_slot[picks[k]].valid = 1'b0;
            dl[0] = a;
            dl[1] = b;
            for (int j = 0; j < 2; j++) begin
                if (dl[j].valid) begin
                    if (free_list.size() > 0) begin
                        w = dl[j];
                        if (w.instruction.rs1 == 0 || hit(cv, ct, w.instruction.rs1))
                            w.src1rdy = 1'b1;
                        if (w.instruction.rs2 == 0 ||
                            (!w.instruction.control.ALUSrc && hit(cv, ct, w.instruction.rs2)))
                            w.src2rdy = 1'b1;
                        m_slot[free_list.pop_front()] = w;
                        if (w.fu == 2'b11) m_bad = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        cnt = 0;
        for (int i = 0; i < RS_DEPTH; i++) if (m_slot[i].valid) cnt++;
        e.ie   = m_ie;
        e.cnt  = CNT_W'(cnt);
        e.full = (int'(RS_DEPTH) - cnt) < 2;
        e.ovf  = m_ovf;
        e.bad  = m_bad;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst, input rsEntry a, input rsEntry b,
                        input logic [2:0] cv, input logic [2:0][5:0] ct, input logic [2:0] fr);
        reset         = rst;
        bus.rsLine_a  = a;
        bus.rsLine_b  = b;
        bus.cdb_valid = cv;
        bus.cdb_tag   = ct;
        bus.fu_ready  = fr;
        model_step(rst, a, b, cv, ct, fr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [2:0] fr);
        step(1'b0, none, none, 3'b000, '0, fr);
    endtask

    function automatic rsEntry mk(input logic [5:0] rd, input logic [5:0] rs1,
                                  input logic [5:0] rs2, input logic alusrc,
                                  input logic [1:0] fu, input logic r1, input logic r2);
        rsEntry r;
        r = '0;
        r.valid                      = 1'b1;
        r.instruction.rd             = rd;
        r.instruction.rs1            = rs1;
        r.instruction.rs2            = rs2;
        r.instruction.imm            = {10'h2a5, rd};
        r.instruction.control.ALUSrc = alusrc;
        r.fu                         = fu;
        r.src1rdy                    = r1;
        r.src2rdy                    = r2;
        return r;
    endfunction

    function automatic rsEntry rnd_entry();
        rsEntry r;
        r = mk(6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        r.valid = ($urandom_range(0, 2) != 0);
        r.instruction.imm = 16'($urandom());
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("issue_valid", 256'(bus.issue_valid), 256'(mon_e.iv));
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("issue_entry[%0d]", k), 256'(bus.issue_entry[k]),
                    256'(mon_e.ie[k]));
            end
            chk("rs_count", 256'(bus.rs_count), 256'(mon_e.cnt));
            chk("rs_full", 256'(bus.rs_full), 256'(mon_e.full));
            chk("overflow_err", 256'(bus.overflow_err), 256'(mon_e.ovf));
            chk("bad_fu_err", 256'(bus.bad_fu_err), 256'(mon_e.bad));
        end
    end

    initial begin
        logic [2:0][5:0] ct;
        rsEntry ra, rb;
        step(1'b1, none, none, 3'b000, '0, 3'b111);
        step(1'b1, none, none, 3'b000, '0, 3'b111);

        // a waits on tag 5, b ready for ALU1; tag 5 broadcast on the MEM port a cycle later
        step(1'b0, mk(6'd1, 6'd5, 6'd0, 1'b0, FU_ALU0, 1'b0, 1'b0),
             mk(6'd2, 6'd0, 6'd7, 1'b1, FU_ALU1, 1'b1, 1'b1), 3'b000, '0, 3'b111);
        idle(3'b111);
        chk("b issues on ALU1", 256'(bus.issue_valid), 256'(3'b010));
        chk("a stays", 256'(bus.rs_count), 256'(1));
        ct = '0;
        ct[2] = 6'd5;
        step(1'b0, none, none, 3'b100, ct, 3'b111);
        chk("no issue on broadcast edge", 256'(bus.issue_valid), 256'(3'b000));
        idle(3'b111);
        chk("a issues on ALU0", 256'(bus.issue_valid), 256'(3'b001));
        chk("a rd", 256'(bus.issue_entry[0].instruction.rd), 256'(1));

        // same-cycle bypass
        ct = '0;
        ct[0] = 6'd9;
        step(1'b0, mk(6'd3, 6'd9, 6'd0, 1'b0, FU_ALU1, 1'b0, 1'b0), none, 3'b001, ct, 3'b111);
        idle(3'b111);
        chk("bypass entry issues", 256'(bus.issue_valid), 256'(3'b010));

        // fill with FUs blocked, then overflow
        for (int p = 0; p < 8; p++) begin
            step(1'b0, mk(6'(10 + 2 * p), 6'd0, 6'd0, 1'b0, 2'(p % 3), 1'b1, 1'b1),
                 mk(6'(11 + 2 * p), 6'd0, 6'd0, 1'b0, 2'((p + 1) % 3), 1'b1, 1'b1),
                 3'b000, '0, 3'b000);
            if (p == 6) chk("two free not full", 256'(bus.rs_full), 256'(0));
        end
        chk("full at 16", 256'(bus.rs_full), 256'(1));
        chk("count 16", 256'(bus.rs_count), 256'(16));
        step(1'b0, mk(6'd60, 6'd0, 6'd0, 1'b0, FU_ALU0, 1'b1, 1'b1),
             mk(6'd61, 6'd0, 6'd0, 1'b0, FU_ALU1, 1'b1, 1'b1), 3'b000, '0, 3'b000);
        chk("overflow flagged", 256'(bus.overflow_err), 256'(1));
        for (int i = 0; i < 8; i++) idle(3'b111);

        // ALU0 ready in slots 2,5,7 among blocked MEM entries; fu_ready[0] gap
        step(1'b1, none, none, 3'b000, '0, 3'b000);
        for (int p = 0; p < 4; p++) begin
            ra = (2 * p == 2) ? mk(6'd2, 6'd0, 6'd0, 1'b0, FU_ALU0, 1'b1, 1'b1)
                              : mk(6'(2 * p), 6'd20, 6'd0, 1'b0, FU_MEM, 1'b0, 1'b1);
            rb = (2 * p + 1 == 5 || 2 * p + 1 == 7)
                 ? mk(6'(2 * p + 1), 6'd0, 6'd0, 1'b0, FU_ALU0, 1'b1, 1'b1)
                 : mk(6'(2 * p + 1), 6'd20, 6'd0, 1'b0, FU_MEM, 1'b0, 1'b1);
            step(1'b0, ra, rb, 3'b000, '0, 3'b000);
        end
        idle(3'b001);
        chk("first from slot 2", 256'(bus.issue_entry[0].instruction.rd), 256'(2));
        idle(3'b000);
        chk("gap cycle no issue", 256'(bus.issue_valid[0]), 256'(0));
        idle(3'b001);
        chk("then slot 5", 256'(bus.issue_entry[0].instruction.rd), 256'(5));
        idle(3'b001);
        chk("then slot 7", 256'(bus.issue_entry[0].instruction.rd), 256'(7));
        ct = '0;
        ct[1] = 6'd20;
        step(1'b0, mk(6'd40, 6'd0, 6'd0, 1'b0, FU_BAD, 1'b1, 1'b1), none, 3'b010, ct, 3'b111);
        chk("bad fu flagged", 256'(bus.bad_fu_err), 256'(1));
        for (int i = 0; i < 6; i++) idle(3'b111);

        // reset dominates pending issue
        step(1'b0, mk(6'd50, 6'd0, 6'd0, 1'b0, FU_ALU0, 1'b1, 1'b1),
             mk(6'd51, 6'd0, 6'd0, 1'b0, FU_MEM, 1'b1, 1'b1), 3'b000, '0, 3'b000);
        step(1'b1, none, none, 3'b000, '0, 3'b111);
        chk("no issue under reset", 256'(bus.issue_valid), 256'(0));
        chk("count cleared", 256'(bus.rs_count), 256'(0));

        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < 3; k++) ct[k] = 6'($urandom_range(0, 7));
            step(($urandom_range(0, 99) == 0), rnd_entry(), rnd_entry(),
                 3'($urandom_range(0, 7)), ct, 3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7)));
        end

        @(posedge clk);
        #2;
        chk("scoreboard drained", 256'(exp_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
